// File: rtl/vmx_pkg.sv
// Shared definitions for the vmx_mm_engine matrix-multiply block:
// FSM state codes, ctrl/flag bit positions and the output conversion helpers.
package vmx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_MAC    = 3'd3,
        ST_WRITE  = 3'd4
    } state_e;

    localparam int CTRL_ABORT     = 0;
    localparam int CTRL_START     = 1;
    localparam int CTRL_SAT       = 2;
    localparam int CTRL_TRANS     = 3;
    localparam int CTRL_ABASE_LSB = 8;
    localparam int CTRL_BBASE_LSB = 16;
    localparam int CTRL_CBASE_LSB = 24;

    localparam int FLAG_DONE    = 8;
    localparam int FLAG_OVF     = 9;
    localparam int FLAG_ROW_LSB = 16;

    // Conversion works on a sign-extended 64-bit view of the accumulator,
    // so ACC_W and OW must both be <= 64.
    localparam int CONV_W = 64;

    function automatic logic signed [CONV_W-1:0] ow_max(input int ow);
        return (64'sd1 <<< (ow - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [CONV_W-1:0] ow_min(input int ow);
        return -(64'sd1 <<< (ow - 1));
    endfunction

    function automatic logic conv_ovf(
        input logic signed [CONV_W-1:0] v,
        input int                       ow
    );
        return (v > ow_max(ow)) || (v < ow_min(ow));
    endfunction

    // Caller keeps the low ow bits: for wrap mode that is plain truncation,
    // for saturate mode the value has already been clamped into range.
    function automatic logic signed [CONV_W-1:0] sat_conv(
        input logic signed [CONV_W-1:0] v,
        input int                       ow,
        input logic                     sat
    );
        if (!sat)            return v;
        if (v > ow_max(ow))  return ow_max(ow);
        if (v < ow_min(ow))  return ow_min(ow);
        return v;
    endfunction

endpackage

// File: rtl/vmx_mac_lane.sv
// One output column of the engine: signed DWxDW multiply into an ACC_W accumulator.
// Ports: clk/rst, en_i (accumulate), clr_i (load product instead of adding),
// sat_i (saturate vs wrap), a_i/b_i operands, res_o converted OW result, ovf_o range flag.
module vmx_mac_lane
    import vmx_pkg::*;
#(
    parameter int N     = 4,
    parameter int DW    = 16,
    parameter int OW    = 2 * DW,
    parameter int ACC_W = 2 * DW + $clog2(N) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 sat_i,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] b_i,
    output logic [OW-1:0]        res_o,
    output logic                 ovf_o
);

    logic signed [2*DW-1:0]   a_x;
    logic signed [2*DW-1:0]   b_x;
    logic signed [2*DW-1:0]   prod;
    logic signed [ACC_W-1:0]  prod_x;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [CONV_W-1:0] acc_w;
    logic signed [CONV_W-1:0] conv;
    logic                     unused_conv_hi;

    assign a_x    = {{DW{a_i[DW-1]}}, a_i};
    assign b_x    = {{DW{b_i[DW-1]}}, b_i};
    assign prod   = a_x * b_x;
    assign prod_x = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};

    always_comb begin
        acc_d = acc_q;
        if (en_i) begin
            acc_d = clr_i ? prod_x : acc_q + prod_x;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_w = {{(CONV_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    assign conv  = sat_conv(acc_w, OW, sat_i);
    assign res_o = conv[OW-1:0];
    assign ovf_o = conv_ovf(acc_w, OW);

    assign unused_conv_hi = ^conv[CONV_W-1:OW];

endmodule

// File: rtl/vmx_mm_engine.sv
// NxN signed matrix-multiply engine (C = A*B or A*B^T) over a single-port word memory.
// Ports: clk, rst (sync high), ctrl (abort/start/sat/transpose/bases), addr, d_i read data,
// wr_en + d_o (one C row over two words), flag (state, done, ovf, current row).
module vmx_mm_engine
    import vmx_pkg::*;
#(
    parameter int N      = 4,
    parameter int DW     = 16,
    parameter int ADDR_W = 8,
    parameter int OW     = 2 * DW,
    parameter int ACC_W  = 2 * DW + $clog2(N) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ctrl,
    output logic [ADDR_W-1:0] addr,
    input  logic [N*DW-1:0]   d_i,
    output logic              wr_en,
    output logic [N*OW-1:0]   d_o,
    output logic [31:0]       flag
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   row_q, row_d;
    logic            start_q;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic            latch;
    logic            sat_q, tr_q;
    logic [7:0]      a_base_q, b_base_q, c_base_q;
    logic [N*OW-1:0] d_o_q;

    logic [N*DW-1:0] a_q [N];
    logic [N*DW-1:0] b_q [N];

    logic                 abort;
    logic                 start_edge;
    logic                 last_cnt;
    logic                 last_row;
    logic                 mac_en;
    logic                 mac_clr;
    logic signed [DW-1:0] a_el;
    logic signed [DW-1:0] b_el [N];
    logic [N*OW-1:0]      row_res;
    logic [N-1:0]         lane_ovf;
    logic                 unused_ctrl;

    assign abort      = ctrl[CTRL_ABORT];
    assign start_edge = ctrl[CTRL_START] & ~start_q;
    assign last_cnt   = (cnt_q == CW'(N - 1));
    assign last_row   = (row_q == CW'(N - 1));
    assign mac_en     = (state_q == ST_MAC);
    assign mac_clr    = (cnt_q == '0);
    assign unused_ctrl = ^ctrl[7:4];

    // A[i][k] is shared by every lane; lane j gets its own B element.
    assign a_el = a_q[row_q][(N-1-int'(cnt_q))*DW +: DW];

    for (genvar j = 0; j < N; j++) begin : g_lane
        assign b_el[j] = tr_q ? b_q[j][(N-1-int'(cnt_q))*DW +: DW]
                              : b_q[cnt_q][(N-1-j)*DW +: DW];

        vmx_mac_lane #(
            .N     (N),
            .DW    (DW),
            .OW    (OW),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .en_i  (mac_en),
            .clr_i (mac_clr),
            .sat_i (sat_q),
            .a_i   (a_el),
            .b_i   (b_el[j]),
            .res_o (row_res[(N-1-j)*OW +: OW]),
            .ovf_o (lane_ovf[j])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        done_d  = done_q;
        ovf_d   = ovf_q;
        latch   = 1'b0;
        addr    = '0;
        wr_en   = 1'b0;
        d_o     = d_o_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_edge && !abort) begin
                    latch   = 1'b1;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    row_d   = '0;
                    state_d = ST_LOAD_A;
                end
            end
            ST_LOAD_A: begin
                addr  = ADDR_W'(a_base_q) + ADDR_W'(cnt_q);
                cnt_d = cnt_q + 1'b1;
                if (last_cnt) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD_B;
                end
            end
            ST_LOAD_B: begin
                addr  = ADDR_W'(b_base_q) + ADDR_W'(cnt_q);
                cnt_d = cnt_q + 1'b1;
                if (last_cnt) begin
                    cnt_d   = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                cnt_d = cnt_q + 1'b1;
                if (last_cnt) begin
                    cnt_d   = '0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr  = ADDR_W'(c_base_q) + ADDR_W'({row_q, 1'b0});
                wr_en = !abort;
                d_o   = abort ? d_o_q : row_res;
                ovf_d = ovf_q | (|lane_ovf);
                if (last_row) begin
                    row_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = ST_MAC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides whatever the state would have done this cycle.
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            row_d   = '0;
            done_d  = done_q;
            ovf_d   = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            row_q    <= '0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            sat_q    <= 1'b0;
            tr_q     <= 1'b0;
            a_base_q <= '0;
            b_base_q <= '0;
            c_base_q <= '0;
            d_o_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            start_q <= ctrl[CTRL_START];
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            if (latch) begin
                sat_q    <= ctrl[CTRL_SAT];
                tr_q     <= ctrl[CTRL_TRANS];
                a_base_q <= ctrl[CTRL_ABASE_LSB +: 8];
                b_base_q <= ctrl[CTRL_BBASE_LSB +: 8];
                c_base_q <= ctrl[CTRL_CBASE_LSB +: 8];
            end
            if (wr_en) begin
                d_o_q <= row_res;
            end
        end
    end

    // Operand register files are fully reloaded on every run, so no reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD_A) begin
            a_q[cnt_q] <= d_i;
        end
        if (state_q == ST_LOAD_B) begin
            b_q[cnt_q] <= d_i;
        end
    end

    assign flag = {8'd0, 8'(row_q), 6'd0, ovf_q, done_q, 5'd0, state_q};

endmodule

// File: tb/tb_vmx_mm_engine.sv
// Directed testbench for vmx_mm_engine with a behavioural single-port word memory.
// Ports: none; drives clk/rst/ctrl and checks flag, addr, wr_en, d_o and memory contents.
module tb_vmx_mm_engine;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int OW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     ctrl;
    logic [AW-1:0]   addr;
    logic [N*DW-1:0] d_i;
    logic            wr_en;
    logic [N*OW-1:0] d_o;
    logic [31:0]     flag;

    logic [N*DW-1:0] mem [256];
    logic            pl_en;
    logic [7:0]      pl_addr;
    logic [N*DW-1:0] pl_data;
    int              wr_cnt;
    logic [7:0]      wr_log [64];

    int n_chk;
    int n_fail;

    vmx_mm_engine #(.N(N), .DW(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst   (rst),
        .ctrl  (ctrl),
        .addr  (addr),
        .d_i   (d_i),
        .wr_en (wr_en),
        .d_o   (d_o),
        .flag  (flag)
    );

    always #5 clk = ~clk;

    assign d_i = mem[addr];

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (wr_en) begin
            mem[addr]         <= d_o[N*OW-1 -: N*DW];
            mem[addr + 8'd1]  <= d_o[N*DW-1:0];
            wr_log[wr_cnt%64] <= addr;
            wr_cnt            <= wr_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] a, input logic [N*DW-1:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    function automatic logic [31:0] mk(input logic [7:0] ab, input logic [7:0] bb,
                                       input logic [7:0] cb, input logic sat,
                                       input logic tr);
        return {cb, bb, ab, 4'b0, tr, sat, 2'b0};
    endfunction

    function automatic logic [N*DW-1:0] row4(input logic [15:0] e0, input logic [15:0] e1,
                                             input logic [15:0] e2, input logic [15:0] e3);
        return {e0, e1, e2, e3};
    endfunction

    function automatic logic [31:0] c_el(input logic [7:0] base, input int i, input int j);
        logic [7:0]  w;
        logic [63:0] word;
        w    = base + 8'(2 * i + j / 2);
        word = mem[w];
        return (j % 2 == 0) ? word[63:32] : word[31:0];
    endfunction

    // Launch one run and count cycles from the start edge until done is seen.
    task automatic run(input logic [31:0] c, output int cyc);
        ctrl = c;
        tick();
        ctrl = c | 32'h2;
        cyc  = 0;
        do begin
            tick();
            cyc++;
            if (cyc == 1) ctrl = c;
        end while (!flag[8] && cyc < 60);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        ctrl  = '0;
        pl_en = 1'b0;
        tick();
        tick();
        n_chk++;
        if (flag !== 32'h0) begin
            n_fail++; $display("FAIL reset_flag: got %h want %h", flag, 32'h0);
        end
        n_chk++;
        if (wr_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en);
        end
        n_chk++;
        if (addr !== 8'h0) begin
            n_fail++; $display("FAIL reset_addr: got %h want 00", addr);
        end
        n_chk++;
        if (d_o !== '0) begin
            n_fail++; $display("FAIL reset_d_o: got %h want 0", d_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_identity();
        int          cyc;
        int          w0;
        logic [63:0] w;
        logic [31:0] exp;
        for (int r = 0; r < N; r++) begin
            w = '0;
            w[(N-1-r)*DW +: DW] = 16'h0001;
            put(8'(r), w);
            w = '0;
            w[(N-1-r)*DW +: DW] = (r % 2 == 1) ? 16'hFFFF : 16'h0001;
            put(8'(4 + r), w);
        end
        for (int r = 8; r < 16; r++) put(8'(r), 64'hAAAA_AAAA_AAAA_AAAA);
        w0 = wr_cnt;
        run(mk(8'h00, 8'h04, 8'h08, 1'b0, 1'b0), cyc);
        n_chk++;
        if (cyc !== 29) begin
            n_fail++; $display("FAIL id_latency: got %0d want 29", cyc);
        end
        n_chk++;
        if (flag[9] !== 1'b0 || flag[2:0] !== 3'd0) begin
            n_fail++; $display("FAIL id_status: got %h want ovf=0 state=0", flag);
        end
        n_chk++;
        if (wr_cnt - w0 !== 4) begin
            n_fail++; $display("FAIL id_writes: got %0d want 4", wr_cnt - w0);
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                exp = (i != j) ? 32'h0 : ((i % 2 == 1) ? 32'hFFFF_FFFF : 32'h1);
                n_chk++;
                if (c_el(8'h08, i, j) !== exp) begin
                    n_fail++;
                    $display("FAIL id_c[%0d][%0d]: got %h want %h", i, j, c_el(8'h08, i, j), exp);
                end
            end
        end
    endtask

    task automatic test_saturate();
        int          cyc;
        logic [31:0] exp;
        for (int r = 0; r < N; r++) begin
            put(8'(8'h10 + r), row4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF));
            put(8'(8'h20 + r), row4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF));
        end
        for (int m = 0; m < 2; m++) begin
            exp = (m == 0) ? 32'h7FFF_FFFF : 32'hFFFC_0004;
            run(mk(8'h10, 8'h20, 8'h30, (m == 0), 1'b0), cyc);
            n_chk++;
            if (flag[9] !== 1'b1 || flag[8] !== 1'b1) begin
                n_fail++; $display("FAIL sat%0d_flags: got %h want done=1 ovf=1", m, flag);
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    n_chk++;
                    if (c_el(8'h30, i, j) !== exp) begin
                        n_fail++;
                        $display("FAIL sat%0d_c[%0d][%0d]: got %h want %h",
                                 m, i, j, c_el(8'h30, i, j), exp);
                    end
                end
            end
        end
    endtask

    task automatic test_transpose();
        int          cyc;
        logic [31:0] exp;
        for (int r = 0; r < N; r++) begin
            put(8'(8'h40 + r), row4(16'd1, 16'd2, 16'd3, 16'd4));
            put(8'(8'h44 + r), row4(16'd1, 16'd2, 16'd3, 16'd4));
        end
        for (int t = 0; t < 2; t++) begin
            run(mk(8'h40, 8'h44, 8'h50, 1'b0, (t == 0)), cyc);
            n_chk++;
            if (flag[9] !== 1'b0 || cyc !== 29) begin
                n_fail++; $display("FAIL tr%0d_status: got flag %h cyc %0d want ovf=0 cyc 29",
                                   t, flag, cyc);
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    exp = (t == 0) ? 32'd30 : 32'(10 * (j + 1));
                    n_chk++;
                    if (c_el(8'h50, i, j) !== exp) begin
                        n_fail++;
                        $display("FAIL tr%0d_c[%0d][%0d]: got %h want %h",
                                 t, i, j, c_el(8'h50, i, j), exp);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int w0;
        int k;
        w0   = wr_cnt;
        ctrl = mk(8'h40, 8'h44, 8'h50, 1'b0, 1'b1);
        tick();
        ctrl[1] = 1'b1;
        repeat (100) tick();
        n_chk++;
        if (wr_cnt - w0 !== 4) begin
            n_fail++; $display("FAIL held_start_writes: got %0d want 4", wr_cnt - w0);
        end
        n_chk++;
        if (flag[8] !== 1'b1 || flag[2:0] !== 3'd0) begin
            n_fail++; $display("FAIL held_start_status: got %h want done=1 idle", flag);
        end
        ctrl[1] = 1'b0;
        tick();
        ctrl[1] = 1'b1;
        tick();
        n_chk++;
        if (flag[8] !== 1'b0 || flag[2:0] !== 3'd1) begin
            n_fail++; $display("FAIL rerun_start: got %h want done=0 state=1", flag);
        end
        k = 0;
        while (!flag[8] && k < 60) begin
            tick();
            k++;
        end
        n_chk++;
        if (flag[8] !== 1'b1 || wr_cnt - w0 !== 8) begin
            n_fail++; $display("FAIL rerun_done: got done %b writes %0d want 1 and 8",
                               flag[8], wr_cnt - w0);
        end
        ctrl = '0;
        tick();
    endtask

    task automatic test_abort();
        int w0;
        int k;
        w0   = wr_cnt;
        ctrl = mk(8'h40, 8'h44, 8'h50, 1'b0, 1'b0);
        tick();
        ctrl[1] = 1'b1;
        k = 0;
        while (!(flag[2:0] == 3'd3 && flag[23:16] == 8'd1) && k < 60) begin
            tick();
            k++;
        end
        n_chk++;
        if (k >= 60) begin
            n_fail++; $display("FAIL abort_reach_mac1: got timeout flag %h want state 3 row 1", flag);
        end
        ctrl[0] = 1'b1;
        tick();
        ctrl[0] = 1'b0;
        n_chk++;
        if (flag[2:0] !== 3'd0 || wr_en !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: got flag %h wr_en %b want state 0 wr_en 0",
                               flag, wr_en);
        end
        repeat (40) tick();
        n_chk++;
        if (wr_cnt - w0 !== 1) begin
            n_fail++; $display("FAIL abort_writes: got %0d want 1", wr_cnt - w0);
        end
        n_chk++;
        if (flag[8] !== 1'b0 || flag[2:0] !== 3'd0) begin
            n_fail++; $display("FAIL abort_done: got %h want done=0 idle", flag);
        end
        n_chk++;
        if (wr_log[w0%64] !== 8'h50) begin
            n_fail++; $display("FAIL abort_row0_addr: got %h want 50", wr_log[w0%64]);
        end
        ctrl = '0;
        tick();
    endtask

    task automatic test_cwrap_rst();
        int          w0;
        int          cyc;
        int          k;
        logic [63:0] w;
        for (int r = 0; r < N; r++) begin
            w = '0;
            w[(N-1-r)*DW +: DW] = 16'h0001;
            put(8'(8'h60 + r), w);
            put(8'(8'h64 + r), w);
        end
        put(8'hFE, 64'hDEAD_BEEF_DEAD_BEEF);
        put(8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
        put(8'h00, 64'hDEAD_BEEF_DEAD_BEEF);
        put(8'h01, 64'hDEAD_BEEF_DEAD_BEEF);
        w0 = wr_cnt;
        run(mk(8'h60, 8'h64, 8'hFE, 1'b0, 1'b0), cyc);
        n_chk++;
        if (wr_log[w0%64] !== 8'hFE || wr_log[(w0+1)%64] !== 8'h00) begin
            n_fail++; $display("FAIL cwrap_addr: got %h %h want fe 00",
                               wr_log[w0%64], wr_log[(w0+1)%64]);
        end
        n_chk++;
        if (mem[8'hFE] !== 64'h0000_0001_0000_0000 || mem[8'hFF] !== 64'h0) begin
            n_fail++; $display("FAIL cwrap_row0: got %h %h want 0000000100000000 0",
                               mem[8'hFE], mem[8'hFF]);
        end
        n_chk++;
        if (mem[8'h00] !== 64'h0000_0000_0000_0001 || mem[8'h01] !== 64'h0) begin
            n_fail++; $display("FAIL cwrap_row1: got %h %h want 0000000000000001 0",
                               mem[8'h00], mem[8'h01]);
        end
        ctrl = mk(8'h60, 8'h64, 8'hFE, 1'b0, 1'b0);
        tick();
        ctrl[1] = 1'b1;
        k = 0;
        while (flag[2:0] != 3'd2 && k < 60) begin
            tick();
            k++;
        end
        n_chk++;
        if (k >= 60) begin
            n_fail++; $display("FAIL rst_reach_loadb: got timeout flag %h want state 2", flag);
        end
        rst = 1'b1;
        tick();
        n_chk++;
        if (flag !== 32'h0 || wr_en !== 1'b0) begin
            n_fail++; $display("FAIL midrun_rst: got flag %h wr_en %b want 0 0", flag, wr_en);
        end
        n_chk++;
        if (addr !== 8'h0 || d_o !== '0) begin
            n_fail++; $display("FAIL midrun_rst_out: got addr %h d_o %h want 0 0", addr, d_o);
        end
        rst  = 1'b0;
        ctrl = '0;
        tick();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        ctrl   = '0;
        pl_en  = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        test_reset();
        test_identity();
        test_saturate();
        test_transpose();
        test_back_to_back();
        test_abort();
        test_cwrap_rst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
